// File: rtl/pattern_gen.sv
// pattern_gen -- animated test-pattern source for the HDMI pixel pipeline.
//
// Purpose:
//   Takes pixel coordinates and a frame-boundary pulse from the timing
//   generator and returns the colour of the addressed pixel, one clock later.
//   Four patterns are available: colour bars, scrolling checkerboard,
//   bouncing box and gradient. All animation state (selected mode, scroll
//   offset, box position/direction, frame counter) changes only on the
//   next_frame pulse, so a frame is always drawn from one consistent state.
//
// Ports:
//   hdmi_clk    in   1  pixel clock, all logic on the rising edge
//   reset       in   1  synchronous active-high reset
//   next_frame  in   1  one-cycle pulse on the last clock of each frame
//   X, Y        in  12  pixel column/row (large values outside active area)
//   mode_i      in   2  pattern select, latched at next_frame
//                       (0 bars, 1 checker, 2 box, 3 gradient)
//   pause       in   1  holds checker scroll and box motion while high
//   RED/GREEN/BLUE out 8 registered colour components
//   frame_cnt   out 16  frames since reset, wraps at 0xFFFF

module pattern_gen #(
    parameter int H_ACTIVE  = 1920,
    parameter int V_ACTIVE  = 1080,
    parameter int BAR_W     = 240,
    parameter int BOX_W     = 128,
    parameter int BOX_H     = 96,
    parameter int STEP      = 4,
    parameter int CHK_SHIFT = 5
) (
    input  logic        hdmi_clk,
    input  logic        reset,
    input  logic        next_frame,
    input  logic [11:0] X,
    input  logic [11:0] Y,
    input  logic [1:0]  mode_i,
    input  logic        pause,
    output logic [7:0]  RED,
    output logic [7:0]  GREEN,
    output logic [7:0]  BLUE,
    output logic [15:0] frame_cnt
);

    localparam logic [11:0] H_ACT_L = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_L = 12'(V_ACTIVE);
    localparam logic [11:0] BOX_W_L = 12'(BOX_W);
    localparam logic [11:0] BOX_H_L = 12'(BOX_H);
    localparam logic [11:0] STEP_L  = 12'(STEP);
    localparam logic [11:0] MAXX_L  = 12'(H_ACTIVE - BOX_W);
    localparam logic [11:0] MAXY_L  = 12'(V_ACTIVE - BOX_H);

    localparam logic [23:0] BOX_RGB = 24'hFF8000;
    localparam logic [23:0] BG_RGB  = 24'h404040;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BOX     = 2'd2,
        MODE_GRAD    = 2'd3
    } mode_e;

    mode_e       modeQ, modeD;
    logic [15:0] frameCntQ, frameCntD;
    logic [11:0] scrollQ, scrollD;
    logic [11:0] boxXQ, boxXD;
    logic [11:0] boxYQ, boxYD;
    logic        dirXQ, dirXD;     // 0 = moving towards larger coordinates
    logic        dirYQ, dirYD;
    logic [23:0] rgbQ, rgbD;

    // One bounce step along a single axis. Returns {newDir, newPos}.
    // Clamping to the wall instead of overshooting keeps the box inside the
    // active area for any STEP up to the box size.
    function automatic logic [12:0] moveAxis(input logic [11:0] pos,
                                             input logic        dirNeg,
                                             input logic [11:0] maxPos);
        logic [12:0] res;
        if (!dirNeg) begin
            if (pos + STEP_L >= maxPos) res = {1'b1, maxPos};
            else                        res = {1'b0, pos + STEP_L};
        end else begin
            if (pos <= STEP_L)          res = {1'b0, 12'd0};
            else                        res = {1'b1, pos - STEP_L};
        end
        return res;
    endfunction

    function automatic logic [23:0] barColour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Animation state update: everything holds except on a frame boundary.
    always_comb begin
        logic [12:0] stepX;
        logic [12:0] stepY;
        modeD     = modeQ;
        frameCntD = frameCntQ;
        scrollD   = scrollQ;
        boxXD     = boxXQ;
        boxYD     = boxYQ;
        dirXD     = dirXQ;
        dirYD     = dirYQ;
        stepX     = moveAxis(boxXQ, dirXQ, MAXX_L);
        stepY     = moveAxis(boxYQ, dirYQ, MAXY_L);
        if (next_frame) begin
            modeD     = mode_e'(mode_i);
            frameCntD = frameCntQ + 16'd1;
            if (!pause) begin
                scrollD = scrollQ + 12'd1;
                boxXD   = stepX[11:0];
                dirXD   = stepX[12];
                boxYD   = stepY[11:0];
                dirYD   = stepY[12];
            end
        end
    end

    // Pixel colour from the current (pre-update) state.
    always_comb begin
        logic [2:0]  barIdx;
        logic [11:0] chkSum;
        logic        inBox;
        barIdx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (X >= 12'(k * BAR_W)) barIdx = 3'(k);
        end
        chkSum = X + scrollQ;
        inBox  = (X >= boxXQ) && (X < boxXQ + BOX_W_L) &&
                 (Y >= boxYQ) && (Y < boxYQ + BOX_H_L);
        rgbD   = 24'h000000;
        if (X < H_ACT_L && Y < V_ACT_L) begin
            case (modeQ)
                MODE_BARS:    rgbD = barColour(barIdx);
                MODE_CHECKER: rgbD = (chkSum[CHK_SHIFT] ^ Y[CHK_SHIFT]) ? 24'h000000 : 24'hFFFFFF;
                MODE_BOX:     rgbD = inBox ? BOX_RGB : BG_RGB;
                default:      rgbD = {X[10:3], Y[10:3], frameCntQ[7:0]};
            endcase
        end
    end

    // State and output registers; reset wins over a frame pulse.
    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            modeQ     <= MODE_BARS;
            frameCntQ <= 16'd0;
            scrollQ   <= 12'd0;
            boxXQ     <= 12'd0;
            boxYQ     <= 12'd0;
            dirXQ     <= 1'b0;
            dirYQ     <= 1'b0;
            rgbQ      <= 24'h000000;
        end else begin
            modeQ     <= modeD;
            frameCntQ <= frameCntD;
            scrollQ   <= scrollD;
            boxXQ     <= boxXD;
            boxYQ     <= boxYD;
            dirXQ     <= dirXD;
            dirYQ     <= dirYD;
            rgbQ      <= rgbD;
        end
    end

    assign RED       = rgbQ[23:16];
    assign GREEN     = rgbQ[15:8];
    assign BLUE      = rgbQ[7:0];
    assign frame_cnt = frameCntQ;

endmodule
